// File: rtl/jtag_target_tap_pkg.sv
// Shared TAP state encoding and instruction opcodes
// for the Jtag target-side responder.
package JtagGlobalPkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tapState_e;

  localparam logic [4:0] INSTR_IDCODE = 5'h01;
  localparam logic [4:0] INSTR_USER   = 5'h02;
  localparam logic [4:0] INSTR_BYPASS = 5'h1F;

endpackage

// File: rtl/jtag_target_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller:
// state register plus next-state logic only.
module jtag_tap_fsm
  import JtagGlobalPkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      jtagTms,
  output tapState_e tapState
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tapState <= TEST_LOGIC_RESET;
    end else begin
      unique case (tapState)
        TEST_LOGIC_RESET:
          tapState <= jtagTms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:
          tapState <= jtagTms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:
          tapState <= jtagTms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:
          tapState <= jtagTms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:
          tapState <= jtagTms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:
          tapState <= jtagTms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:
          tapState <= jtagTms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:
          tapState <= jtagTms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:
          tapState <= jtagTms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:
          tapState <= jtagTms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:
          tapState <= jtagTms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:
          tapState <= jtagTms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:
          tapState <= jtagTms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:
          tapState <= jtagTms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:
          tapState <= jtagTms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:
          tapState <= jtagTms ? SELECT_DR : RUN_TEST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jtag_target_tap.sv
// Target-side JTAG TAP: IR, BYPASS, IDCODE and one
// user data register behind the 1149.1 controller.
module jtag_target_tap
  import JtagGlobalPkg::*;
#(
  parameter int          IR_WIDTH      = 5,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1A2B_3C5D,
  parameter int          USER_DR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     jtagTms,
  input  logic                     jtagSerialIn,
  output logic                     jtagSerialOut,
  output logic [3:0]               tapState,
  output logic [IR_WIDTH-1:0]      irValue,
  input  logic [USER_DR_WIDTH-1:0] userDrIn,
  output logic [USER_DR_WIDTH-1:0] userDrOut,
  output logic                     userDrUpdate
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(INSTR_USER);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tapState_e                st;
  logic [IR_WIDTH-1:0]      irShift;
  logic [31:0]              idShift;
  logic [USER_DR_WIDTH-1:0] userShift;
  logic                     bypassReg;
  logic                     selId;
  logic                     selUser;
  logic                     enterTlr;

  jtag_tap_fsm uFsm (
    .clk      (clk),
    .reset    (reset),
    .jtagTms  (jtagTms),
    .tapState (st)
  );

  assign tapState = st;
  assign selId    = (irValue == IR_IDCODE);
  assign selUser  = (irValue == IR_USER);
  // irValue must already read IDCODE on the first cycle spent in TLR
  assign enterTlr = (st == TEST_LOGIC_RESET) ||
                    (st == SELECT_IR && jtagTms);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irValue <= IR_IDCODE;
    end else if (enterTlr) begin
      irValue <= IR_IDCODE;
    end else if (st == UPDATE_IR) begin
      irValue <= irShift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irShift      <= '0;
      idShift      <= '0;
      userShift    <= '0;
      bypassReg    <= 1'b0;
      userDrOut    <= '0;
      userDrUpdate <= 1'b0;
    end else begin
      userDrUpdate <= 1'b0;
      case (st)
        CAPTURE_IR: irShift <= IR_CAPTURE;
        SHIFT_IR:
          irShift <= {jtagSerialIn, irShift[IR_WIDTH-1:1]};
        CAPTURE_DR: begin
          if (selId)        idShift   <= IDCODE_VALUE;
          else if (selUser) userShift <= userDrIn;
          else              bypassReg <= 1'b0;
        end
        SHIFT_DR: begin
          if (selId)
            idShift <= {jtagSerialIn, idShift[31:1]};
          else if (selUser)
            userShift <= {jtagSerialIn, userShift[USER_DR_WIDTH-1:1]};
          else
            bypassReg <= jtagSerialIn;
        end
        UPDATE_DR: begin
          if (selUser) begin
            userDrOut    <= userShift;
            userDrUpdate <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    jtagSerialOut = 1'b0;
    if (st == SHIFT_IR) begin
      jtagSerialOut = irShift[0];
    end else if (st == SHIFT_DR) begin
      unique case (1'b1)
        selId:   jtagSerialOut = idShift[0];
        selUser: jtagSerialOut = userShift[0];
        default: jtagSerialOut = bypassReg;
      endcase
    end
  end

endmodule
